// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexes one shared code decoder across four digits with blanking and frame-synchronous data updates.
module display_scan_ctrl #(
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_valid,
  input  logic [19:0] wr_data,
  output logic        wr_ready,
  output logic        c1,
  output logic        c2,
  output logic        c3,
  output logic        c4,
  output logic        c5,
  output logic [3:0]  an,
  output logic        frame_done
);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam logic [15:0] SHOW_LAST  = 16'(SHOW_CYCLES - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] act_q, act_d, pend_q, pend_d, act_sh;
  logic        pend_empty_q, pend_empty_d, frame_d, commit;
  logic [3:0]  an_q, an_d;
  logic [4:0]  c_q, c_d;
  logic        frame_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else if (state_q == BLANK && cnt_q == BLANK_LAST) begin
      state_d = SHOW;
      cnt_d   = '0;
    end else if (state_q == SHOW && cnt_q == SHOW_LAST) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = idx_q + 2'd1;
      frame_d = idx_q == 2'd3;
    end
    // pending data only lands on a frame boundary, or straight away while parked
    commit       = !pend_empty_q && (state_q == IDLE || frame_d);
    act_d        = commit ? pend_q : act_q;
    pend_d       = (wr_valid && pend_empty_q) ? wr_data : pend_q;
    pend_empty_d = commit || (pend_empty_q && !wr_valid);
    act_sh       = act_d >> ({3'b000, idx_d} * 5'd5);
    c_d          = state_d == IDLE ? 5'd0 : act_sh[4:0];
    an_d         = state_d == SHOW ? ~(4'b0001 << idx_d) : 4'hF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_q        <= '0;
      pend_q       <= '0;
      pend_empty_q <= 1'b1;
      an_q         <= 4'hF;
      c_q          <= '0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_empty_q <= pend_empty_d;
      an_q         <= an_d;
      c_q          <= c_d;
      frame_q      <= frame_d;
    end
  end
  assign wr_ready           = pend_empty_q;
  assign an                 = an_q;
  assign frame_done         = frame_q;
  assign {c1, c2, c3, c4, c5} = c_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scenarios plus random traffic checked against a position-in-frame reference model.
module tb_display_scan_ctrl;
  localparam int SHOW  = 3;
  localparam int BLANK = 1;
  localparam int SLOT  = SHOW + BLANK;
  localparam int FRAME = 4 * SLOT;
  logic clk = 0, rst = 0, en = 0, wr_valid = 0;
  logic [19:0] wr_data = '0;
  logic wr_ready, c1, c2, c3, c4, c5, frame_done;
  logic [3:0] an;
  int checks = 0, errors = 0;
  bit running = 0, m_full = 0, m_fd = 0;
  int pos = 0;
  logic [4:0] m_act [4] = '{default: 5'd0};
  logic [19:0] m_pend = '0;
  display_scan_ctrl #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
    .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic int slot_of();
    return (pos / SLOT) % 4;
  endfunction
  function automatic bit in_show();
    return running && (pos % SLOT) >= BLANK;
  endfunction
  task automatic model_step(input logic r, input logic e, input logic v, input logic [19:0] d);
    bit acc, was_idle;
    if (r) begin
      running = 0;
      pos = 0;
      m_act = '{default: 5'd0};
      m_full = 0;
      m_fd = 0;
    end else begin
      acc = v && !m_full;
      was_idle = !running;
      if (!e) running = 0;
      else if (!running) begin
        running = 1;
        pos = 0;
      end else pos++;
      m_fd = running && !was_idle && pos % FRAME == 0;
      if (m_full && (was_idle || m_fd)) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_pend[5*i +: 5];
        m_full = 0;
      end
      if (acc) begin
        m_pend = d;
        m_full = 1;
      end
    end
  endtask
  task automatic tick(input logic r, input logic e, input logic v, input logic [19:0] d);
    logic [3:0] exp_an;
    logic [4:0] exp_c;
    rst = r;
    en = e;
    wr_valid = v;
    wr_data = d;
    @(posedge clk);
    model_step(r, e, v, d);
    #1;
    exp_an = in_show() ? ~(4'b0001 << slot_of()) : 4'hF;
    exp_c = running ? m_act[slot_of()] : 5'd0;
    check("an", 32'(an), 32'(exp_an));
    check("code", 32'({c1, c2, c3, c4, c5}), 32'(exp_c));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("wr_ready", 32'(wr_ready), 32'(!m_full));
  endtask
  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) tick(0, e, 0, '0);
  endtask
  task automatic wait_show(input int k);
    int n = 0;
    while (!(in_show() && slot_of() == k) && n < 64) begin
      tick(0, 1, 0, '0);
      n++;
    end
    check("wait_show", 32'(n < 64), 32'd1);
  endtask
  initial begin
    int n;
    tick(1, 1, 1, 20'hABCDE);
    tick(1, 1, 1, 20'h12345);
    run(2, 0);
    tick(0, 0, 1, {5'd3, 5'd2, 5'd1, 5'd0});
    run(2, 0);
    run(40, 1);
    wait_show(1);
    tick(0, 1, 1, 20'hFFFFF);
    run(40, 1);
    tick(0, 1, 1, 20'h0A5A5);
    n = 0;
    while (!m_full && n < 40) begin
      tick(0, 1, 1, 20'h0A5A5);
      n++;
    end
    n = 0;
    while (m_full && n < 40) begin
      tick(0, 1, 1, 20'h5A5A5);
      n++;
    end
    check("backpressure_bound", 32'(n < 40), 32'd1);
    tick(0, 1, 0, '0);
    run(40, 1);
    wait_show(2);
    run(3, 0);
    run(20, 1);
    tick(0, 1, 1, 20'h77777);
    wait_show(3);
    tick(1, 1, 1, 20'h33333);
    run(20, 1);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 49) != 0,
           $urandom_range(0, 7) == 0, 20'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
